// File: rtl/fp_add_checker.sv
// fp_add_checker: sequenced multi-vector self-check of a single-precision adder.
// Ports: clk/reset (async active-low), start/compare_mode/halt_on_fail controls,
//   mem_en/mem_addr/mem_data memory read port (1-cycle latency), status and count outputs.
// Each vector takes 5 cycles (REQ_A, REQ_B, REQ_E, CAP_E, CMP); start is ignored while busy.

// fp_adder: combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Ports: a, b operands; sum result. Subnormals are handled and results overflow to infinity.
// Any NaN input, or infinities of opposite sign, produce the canonical quiet NaN.
module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic [31:0] x, y;           // x has the larger magnitude
  logic [7:0]  ex, ey, d;
  logic [26:0] mx, my, my_al;  // {hidden, fraction, guard, round, sticky}
  logic        sticky;
  logic [27:0] s;
  logic [26:0] norm;
  logic [9:0]  e_r;
  logic [24:0] mant;
  logic        round_up;

  always_comb begin
    sum      = 32'd0;
    x        = (a[30:0] < b[30:0]) ? b : a;
    y        = (a[30:0] < b[30:0]) ? a : b;
    // Subnormals share the exponent of the smallest normal, without a hidden bit.
    ex       = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey       = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx       = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    my       = {(y[30:23] != 8'd0), y[22:0], 3'b000};
    d        = ex - ey;
    my_al    = 27'd0;
    sticky   = 1'b0;
    s        = 28'd0;
    norm     = 27'd0;
    e_r      = 10'd0;
    mant     = 25'd0;
    round_up = 1'b0;

    if (d > 8'd26) begin
      my_al  = 27'd0;
      sticky = |my;
    end else begin
      my_al  = my >> d;
      sticky = |(my & ~(27'h7FF_FFFF << d));
    end
    my_al[0] = my_al[0] | sticky;

    if (x[31] ^ y[31]) s = {1'b0, mx} - {1'b0, my_al};
    else               s = {1'b0, mx} + {1'b0, my_al};

    e_r = {2'b00, ex};
    if (s[27]) begin
      norm = {s[27:2], s[1] | s[0]};
      e_r  = e_r + 10'd1;
    end else begin
      norm = s[26:0];
      // Left-normalise, but stop at the minimum exponent so tiny results go subnormal.
      for (int i = 0; i < 26; i++) begin
        if (!norm[26] && e_r > 10'd1) begin
          norm = norm << 1;
          e_r  = e_r - 10'd1;
        end
      end
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant     = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mant[24]) begin
      mant = mant >> 1;
      e_r  = e_r + 10'd1;
    end

    if (x[30:23] == 8'hFF) begin
      if (x[22:0] != 23'd0 || (y[30:23] == 8'hFF && (x[31] ^ y[31])))
        sum = 32'h7FC0_0000;
      else
        sum = x;
    end else if (s == 28'd0) begin
      // Exact cancellation gives +0 unless both operands were negative.
      sum = {x[31] & y[31], 31'd0};
    end else if (e_r >= 10'd255) begin
      sum = {x[31], 8'hFF, 23'd0};
    end else begin
      sum = {x[31], (mant[23] ? e_r[7:0] : 8'd0), mant[22:0]};
    end
  end

endmodule

module fp_add_checker #(
  parameter int NUM_VECTORS = 4,
  parameter int ADDR_W      = 5,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              compare_mode,
  input  logic              halt_on_fail,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              all_pass,
  output logic              led,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [31:0]       last_sum
);

  typedef enum logic [2:0] {
    IDLE, REQ_A, REQ_B, REQ_E, CAP_E, CMP, DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   idx;
  logic [ADDR_W-1:0]  base;   // 3*idx, tracked incrementally
  logic [31:0]        a_q, b_q, e_q;
  logic [31:0]        sum_w;
  logic [30:0]        mag_diff;
  logic               match;
  logic               last_vec;

  fp_adder u_adder (
    .a   (a_q),
    .b   (b_q),
    .sum (sum_w)
  );

  always_comb begin
    mag_diff = (sum_w[30:0] >= e_q[30:0]) ? (sum_w[30:0] - e_q[30:0])
                                          : (e_q[30:0] - sum_w[30:0]);
    if (compare_mode) match = (sum_w[31] == e_q[31]) && (mag_diff <= 31'd1);
    else              match = (sum_w == e_q);
  end

  assign last_vec = (idx == CNT_W'(NUM_VECTORS - 1));
  assign led      = all_pass;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      mem_en         <= 1'b0;
      mem_addr       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '1;
      last_sum       <= 32'd0;
      idx            <= '0;
      base           <= '0;
      a_q            <= 32'd0;
      b_q            <= 32'd0;
      e_q            <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= REQ_A;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '1;
            idx            <= '0;
            base           <= '0;
            mem_en         <= 1'b1;
            mem_addr       <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            all_pass       <= 1'b0;
          end
        end
        REQ_A: begin
          mem_addr <= base + ADDR_W'(1);
          state    <= REQ_B;
        end
        REQ_B: begin
          a_q      <= mem_data;
          mem_addr <= base + ADDR_W'(2);
          state    <= REQ_E;
        end
        REQ_E: begin
          b_q    <= mem_data;
          mem_en <= 1'b0;
          state  <= CAP_E;
        end
        CAP_E: begin
          e_q   <= mem_data;
          state <= CMP;
        end
        CMP: begin
          last_sum <= sum_w;
          if (match) begin
            pass_count <= pass_count + CNT_W'(1);
          end else begin
            fail_count <= fail_count + CNT_W'(1);
            if (fail_count == '0) first_fail_idx <= idx;
          end
          if ((!match && halt_on_fail) || last_vec) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            all_pass <= match && (fail_count == '0);
          end else begin
            idx      <= idx + CNT_W'(1);
            base     <= base + ADDR_W'(3);
            mem_en   <= 1'b1;
            mem_addr <= base + ADDR_W'(3);
            state    <= REQ_A;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_checker.sv
// tb_fp_add_checker: directed test of fp_add_checker with a 1-cycle-latency memory.
// Vectors: 93.0+12.8125, 1+1, 2+3, 1+(-0.5); expected sums computed by hand.
module tb_fp_add_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        compare_mode;
  logic        halt_on_fail;
  logic        mem_en;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        busy, done, all_pass, led;
  logic [7:0]  pass_count, fail_count, first_fail_idx;
  logic [31:0] last_sum;

  logic [31:0] mem [0:31];
  int checks = 0;
  int errors = 0;

  fp_add_checker #(.NUM_VECTORS(4), .ADDR_W(5), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .compare_mode   (compare_mode),
    .halt_on_fail   (halt_on_fail),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .busy           (busy),
    .done           (done),
    .all_pass       (all_pass),
    .led            (led),
    .pass_count     (pass_count),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .last_sum       (last_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives start so that it is sampled at the next rising edge (E0); returns #1 after E0.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  // From #1 after E0, advance to #1 after edge n-1 and n, checking done rises exactly at n.
  task automatic expect_done_at(input string tag, input int n);
    repeat (n - 1) @(posedge clk);
    #1 check({tag, "_done_early"}, {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic expect_counts(input string tag, input int p, input int f, input logic [7:0] ffi, input logic ap);
    check({tag, "_pass"}, {24'd0, pass_count}, p);
    check({tag, "_fail"}, {24'd0, fail_count}, f);
    check({tag, "_ffi"}, {24'd0, first_fail_idx}, {24'd0, ffi});
    check({tag, "_all_pass"}, {31'd0, all_pass}, {31'd0, ap});
    check({tag, "_led"}, {31'd0, led}, {31'd0, ap});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[0]  = 32'h42BA_0000; mem[1]  = 32'h414D_0000; mem[2]  = 32'h42D3_A000;
    mem[3]  = 32'h3F80_0000; mem[4]  = 32'h3F80_0000; mem[5]  = 32'h4000_0000;
    mem[6]  = 32'h4000_0000; mem[7]  = 32'h4040_0000; mem[8]  = 32'h40A0_0000;
    mem[9]  = 32'h3F80_0000; mem[10] = 32'hBF00_0000; mem[11] = 32'h3F00_0000;

    reset = 1'b0; start = 1'b0; compare_mode = 1'b0; halt_on_fail = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    check("rst_last_sum", last_sum, 32'd0);
    expect_counts("rst", 0, 0, 8'hFF, 1'b0);

    @(negedge clk) reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_mem_en", {31'd0, mem_en}, 32'd0);

    // All vectors correct.
    pulse_start();
    check("run1_busy", {31'd0, busy}, 32'd1);
    check("run1_mem_en", {31'd0, mem_en}, 32'd1);
    expect_done_at("run1", 20);
    expect_counts("run1", 4, 0, 8'hFF, 1'b1);
    check("run1_last_sum", last_sum, 32'h3F00_0000);

    // Vector 2 expected value corrupted; restart from DONE.
    mem[8] = 32'h40A0_0005;
    pulse_start();
    check("run2_clr_done", {31'd0, done}, 32'd0);
    check("run2_clr_pass", {24'd0, pass_count}, 32'd0);
    expect_done_at("run2", 20);
    expect_counts("run2", 3, 1, 8'd2, 1'b0);

    // Same corruption, halting at the first mismatch.
    halt_on_fail = 1'b1;
    pulse_start();
    expect_done_at("run3", 15);
    expect_counts("run3", 2, 1, 8'd2, 1'b0);
    check("run3_last_sum", last_sum, 32'h40A0_0000);
    halt_on_fail = 1'b0;
    mem[8] = 32'h40A0_0000;

    // Vector 0 expected off by one ULP.
    mem[2] = 32'h42D3_A001;
    compare_mode = 1'b0;
    pulse_start();
    expect_done_at("ulp_exact", 20);
    expect_counts("ulp_exact", 3, 1, 8'd0, 1'b0);
    check("ulp_exact_last_sum", last_sum, 32'h3F00_0000);
    compare_mode = 1'b1;
    pulse_start();
    expect_done_at("ulp_tol", 20);
    expect_counts("ulp_tol", 4, 0, 8'hFF, 1'b1);

    // Sign-flipped expectation fails in both modes.
    mem[2] = 32'hC2D3_A000;
    pulse_start();
    expect_done_at("sign_tol", 20);
    expect_counts("sign_tol", 3, 1, 8'd0, 1'b0);
    compare_mode = 1'b0;
    pulse_start();
    expect_done_at("sign_exact", 20);
    expect_counts("sign_exact", 3, 1, 8'd0, 1'b0);
    mem[2] = 32'h42D3_A000;

    // Start pulsed at cycle 7 of a run is ignored.
    pulse_start();
    repeat (6) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("ign_done_early", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 check("ign_done", {31'd0, done}, 32'd1);
    expect_counts("ign", 4, 0, 8'hFF, 1'b1);

    // Reset at cycle 9 aborts immediately.
    pulse_start();
    repeat (8) @(posedge clk);
    #1 check("pre_rst_pass", {24'd0, pass_count}, 32'd1);
    @(negedge clk) reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
    expect_counts("mid_rst", 0, 0, 8'hFF, 1'b0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    pulse_start();
    expect_done_at("fresh", 20);
    expect_counts("fresh", 4, 0, 8'hFF, 1'b1);
    check("fresh_last_sum", last_sum, 32'h3F00_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_checker.md
# fp_add_checker

Parametrised, self-checking floating-point adder test engine. On `start`, it walks NUM_VECTORS test vectors held in the VEDA memory (operand A, operand B, expected sum), runs each pair through the combinational `fp_adder`, and compares the sum against the stored result. It then reports pass/fail counts, the first failing index and a board-level pass LED. It replaces the single-vector, switch-selected top-level check with a sequenced, multi-vector run.

## Interface
- NUM_VECTORS, 4, number of test vectors read per run (≥1)
- ADDR_W, 5, memory address width; 3·NUM_VECTORS ≤ 2^ADDR_W
- CNT_W, 8, width of counters and index outputs; NUM_VECTORS < 2^CNT_W − 1

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; forces all state to reset values immediately
- start  in  1  one-cycle request to begin a run; sampled only in IDLE or DONE
- compare_mode  in  1  0 = exact bitwise compare; 1 = ±1 ULP tolerance
- halt_on_fail  in  1  1 = end run at first mismatch
- mem_en  out  1  read enable to VEDA (mode=1, write_enable=0 tied at instantiation)
- mem_addr  out  ADDR_W  VEDA read address
- mem_data  in  32  VEDA read data, valid one cycle after address/enable
- busy  out  1  run in progress
- done  out  1  run complete; held until next accepted start or reset
- all_pass  out  1  done && fail_count==0
- led  out  1  equals all_pass
- pass_count  out  CNT_W  vectors that matched
- fail_count  out  CNT_W  vectors that mismatched
- first_fail_idx  out  CNT_W  index of first mismatch; all-ones = none
- last_sum  out  32  fp_adder output captured at the most recent compare

## Operation
- Memory layout: vector i has A at 3i, B at 3i+1 and expected sum at 3i+2.
- Contains one `fp_adder` instance. Its inputs are registers a_q and b_q. Its output is compared against register e_q.
- FSM states: IDLE, REQ_A, REQ_B, REQ_E, CAP_E, CMP, DONE.
  - IDLE/DONE: if start, clear counters, set first_fail_idx to all-ones, set idx=0, go to REQ_A.
  - REQ_A: mem_en=1, mem_addr=3·idx.
  - REQ_B: mem_en=1, mem_addr=3·idx+1; capture mem_data into a_q.
  - REQ_E: mem_en=1, mem_addr=3·idx+2; capture into b_q.
  - CAP_E: capture into e_q.
  - CMP: evaluate match; increment pass_count or fail_count; on the first fail, load first_fail_idx=idx; load last_sum.
    - If (fail && halt_on_fail) or idx==NUM_VECTORS−1, go to DONE.
    - Else idx++ and go to REQ_A.
- Match rules:
  - compare_mode=0: sum == e_q.
  - compare_mode=1: sign bits are equal and |sum[30:0] − e_q[30:0]| ≤ 1 as unsigned integers.
- mem_addr is held at the last value when mem_en=0.
- start while busy is ignored. compare_mode and halt_on_fail are sampled live in CMP.

## Timing
- Reset values: state IDLE; mem_en, busy, done, all_pass, led = 0; mem_addr, idx, pass_count, fail_count, last_sum = 0; first_fail_idx = all-ones.
- busy = 1 in REQ_A..CMP.
- Each vector takes 5 cycles. With start sampled at edge E0, DONE is entered at edge E(5·k), where k is the number of vectors processed. A full run is 5·NUM_VECTORS cycles.
- Counters update at the edge leaving CMP. done and all_pass go high at the same edge.
- A start in DONE restarts the run: done drops at the next edge and counters clear at that edge.
- Reset asserted mid-run: immediate return to IDLE with reset values. The partial run is lost.

## Test plan
- Reset → all outputs at their reset values, first_fail_idx=0xFF, mem_en=0; start held low keeps IDLE indefinitely.
- NUM_VECTORS=4 with vectors (0x42BA0000+0x414D0000→0x42D3A000), (0x3F800000+0x3F800000→0x40000000), plus two further correct vectors; 1-cycle-latency memory model → done at edge 20 after start, pass_count=4, fail_count=0, led=1, last_sum matches vector 3.
- Same run with vector 2's expected value corrupted → pass_count=3, fail_count=1, first_fail_idx=2, all_pass=0, led=0.
- Corrupted vector 2 with halt_on_fail=1 → done at edge 15, pass_count=2, fail_count=1, first_fail_idx=2.
- Vector 0 expected 0x42D3A001 → fails with compare_mode=0; passes with compare_mode=1; 0xC2D3A000 (sign flipped) fails in both modes.
- Start pulsed at cycle 7 of a run → ignored, run unaffected. Reset pulsed at cycle 9 → IDLE immediately, counters at 0. A fresh start then completes a normal 20-cycle run.
